ppu_vram_responder: RTL

- Memory-side end of the PPU's multiplexed VRAM bus (14-bit address/data lines, ALE, active-low /RD and /WR).
- Latches the address on ALE and returns read data while /RD is low. Commits write data on /WR.
- Owns the 2 KB nametable RAM (CIRAM), with cartridge-selected mirroring, and an optional 8 KB CHR RAM.
- Sits between the PPU bus initiator and the top level, which merges bus_data_OUT/bus_data_OE onto the shared tri-state lines.

---
 rtl/ppu_vram_responder_if.sv | 24 ++
 rtl/ppu_vram_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_responder_if.sv
// PPU VRAM bus bundle: multiplexed address/data lines, ALE, active-low strobes,
// cartridge mirroring select, and the responder's read-data return path.
//   master : PPU-side initiator, drives address/data, strobes and mirroring
//   slave  : memory-side responder, drives read data, output enable and error pulse
interface ppu_vram_responder_if;
    logic [13:0] bus_addrData_IN;
    logic        addressLatch_EN;
    logic        read_EN;
    logic        write_EN;
    logic [1:0]  mirror_SEL;
    logic [7:0]  bus_data_OUT;
    logic        bus_data_OE;
    logic        protocol_error_OUT;

    modport master (
        output bus_addrData_IN, addressLatch_EN, read_EN, write_EN, mirror_SEL,
        input  bus_data_OUT, bus_data_OE, protocol_error_OUT
    );

    modport slave (
        input  bus_addrData_IN, addressLatch_EN, read_EN, write_EN, mirror_SEL,
        output bus_data_OUT, bus_data_OE, protocol_error_OUT
    );
endinterface

// File: rtl/ppu_vram_responder.sv
// Memory-side responder of the PPU VRAM bus. Latches the address on ALE, answers
// /RD with one-edge RAM latency and commits /WR once per strobe. Owns the 2 KB
// nametable RAM (CIRAM, cartridge-selected mirroring) and an optional 8 KB CHR RAM.
// Ports:
//   clock_IN  - system clock, all logic on posedge
//   reset_IN  - synchronous active-high reset (RAM contents are kept)
//   bus       - slave side of ppu_vram_responder_if (address/data, ALE, /RD, /WR,
//               mirror select in; read data, output enable, protocol error out)
module ppu_vram_responder #(
    parameter bit          CHR_RAM_EN    = 1'b1,
    parameter int unsigned NT_ADDR_BITS  = 11,
    parameter int unsigned CHR_ADDR_BITS = 13
) (
    input  logic                  clock_IN,
    input  logic                  reset_IN,
    ppu_vram_responder_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StLatched, StRead, StWrite} state_e;

    state_e      state_q;
    logic [13:0] addrLatch_q;
    logic [7:0]  dataOut_q;
    logic        dataOe_q;
    logic        protoErr_q;
    logic        readPrev_q;
    logic        writePrev_q;
    logic        rdHit_q;
    logic        rdIsNt_q;
    logic [7:0]  ntRdData_q;
    logic [7:0]  chrRdData;
    logic [7:0]  rdData;

    // Address decode of the held latch
    logic                     isChr;
    logic                     isNt;
    logic                     isHit;
    logic                     ntSel;
    logic [NT_ADDR_BITS-1:0]  ntIdx;
    logic [CHR_ADDR_BITS-1:0] chrIdx;

    assign isChr  = CHR_RAM_EN && !addrLatch_q[13];
    // 0x2000-0x3EFF; 0x3Fxx belongs to the PPU's internal palette
    assign isNt   = addrLatch_q[13] && (addrLatch_q[13:8] != 6'h3F);
    assign isHit  = isChr || isNt;
    assign chrIdx = addrLatch_q[CHR_ADDR_BITS-1:0];

    always_comb begin
        ntSel = 1'b0;
        unique case (bus.mirror_SEL)
            2'd0: ntSel = addrLatch_q[11]; // horizontal
            2'd1: ntSel = addrLatch_q[10]; // vertical
            2'd2: ntSel = 1'b0;            // single-screen A
            2'd3: ntSel = 1'b1;            // single-screen B
        endcase
    end

    assign ntIdx = NT_ADDR_BITS'({ntSel, addrLatch_q[9:0]});

    // Strobe qualification
    logic readFall;
    logic writeFall;
    logic bothLow;
    logic strobeOk;
    logic rdFire;
    logic wrStart;
    logic wrCommit;

    assign readFall  = readPrev_q && !bus.read_EN;
    assign writeFall = writePrev_q && !bus.write_EN;
    assign bothLow   = !bus.read_EN && !bus.write_EN;
    // IDLE serves strobes from the still-held latch, just like LATCHED
    assign strobeOk  = !bus.addressLatch_EN && ((state_q == StIdle) || (state_q == StLatched));
    assign rdFire    = strobeOk && readFall && bus.write_EN;
    assign wrStart   = strobeOk && writeFall && bus.read_EN;
    assign wrCommit  = wrStart && !reset_IN;

    // Nametable RAM: synchronous read captured on the strobe edge
    logic [7:0] ciram [0:(1 << NT_ADDR_BITS) - 1];

    always_ff @(posedge clock_IN) begin
        if (wrCommit && isNt) begin
            ciram[ntIdx] <= bus.bus_addrData_IN[7:0];
        end
        if (rdFire && isNt) begin
            ntRdData_q <= ciram[ntIdx];
        end
    end

    generate
        if (CHR_RAM_EN) begin : gChr
            logic [7:0] chrRam [0:(1 << CHR_ADDR_BITS) - 1];
            logic [7:0] chrRd_q;

            always_ff @(posedge clock_IN) begin
                if (wrCommit && isChr) begin
                    chrRam[chrIdx] <= bus.bus_addrData_IN[7:0];
                end
                if (rdFire && isChr) begin
                    chrRd_q <= chrRam[chrIdx];
                end
            end

            assign chrRdData = chrRd_q;
        end else begin : gNoChr
            assign chrRdData = 8'h00;
        end
    endgenerate

    assign rdData = rdIsNt_q ? ntRdData_q : chrRdData;

    // Bus FSM with registered outputs
    always_ff @(posedge clock_IN) begin
        if (reset_IN) begin
            state_q     <= StIdle;
            addrLatch_q <= 14'h0000;
            dataOut_q   <= 8'h00;
            dataOe_q    <= 1'b0;
            protoErr_q  <= 1'b0;
            readPrev_q  <= 1'b1;
            writePrev_q <= 1'b1;
            rdHit_q     <= 1'b0;
            rdIsNt_q    <= 1'b0;
        end else begin
            readPrev_q  <= bus.read_EN;
            writePrev_q <= bus.write_EN;
            protoErr_q  <= 1'b0;

            if (bus.addressLatch_EN) begin
                addrLatch_q <= bus.bus_addrData_IN;
                state_q     <= StLatched;
                dataOe_q    <= 1'b0;
            end else if (bothLow) begin
                // Pulse only when the illegal combination first appears
                protoErr_q <= readPrev_q || writePrev_q;
                dataOe_q   <= 1'b0;
                state_q    <= StIdle;
            end else begin
                case (state_q)
                    StIdle, StLatched: begin
                        if (rdFire) begin
                            state_q  <= StRead;
                            rdHit_q  <= isHit;
                            rdIsNt_q <= isNt;
                        end else if (wrStart) begin
                            state_q <= StWrite;
                        end
                    end
                    StRead: begin
                        if (bus.read_EN) begin
                            dataOe_q <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            dataOut_q <= rdHit_q ? rdData : 8'h00;
                            dataOe_q  <= rdHit_q;
                        end
                    end
                    StWrite: begin
                        if (bus.write_EN) begin
                            state_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.bus_data_OUT       = dataOut_q;
    assign bus.bus_data_OE        = dataOe_q;
    assign bus.protocol_error_OUT = protoErr_q;

endmodule
